cla_pipelined_adder: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor for the integer datapath; successor to the fixed 2-bit lookahead carry unit.
- Width, lookahead group size and pipeline depth are configurable.
- Supports add, sub, add-with-carry and sub-with-borrow, and produces C/V/Z/N flags.
- Sits between the ALU operand mux and the writeback register, with valid/ready back-pressure on both sides.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/cla_group_unit.sv | 52 +++++
 rtl/cla_pipelined_adder.sv | 265 ++++++++++++++++++++++++++
 tb/tb_cla_pipelined_adder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the integer adder datapath: op encodings, flag bit
// positions and a helper that sizes the second-level lookahead units.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBB = 2'b11
  } op_e;

  // Bit positions inside the packed flag register.
  localparam int FLAG_C    = 0;
  localparam int FLAG_V    = 1;
  localparam int FLAG_Z    = 2;
  localparam int FLAG_N    = 3;
  localparam int NUM_FLAGS = 4;

  // Size of one second-level lookahead unit covering ng groups. Up to eight
  // groups fit in one unit; wider words are split into equal chunks of at
  // most eight groups that ripple into each other.
  function automatic int lka_chunk(input int ng);
    int r;
    if (ng <= 8) begin
      r = ng;
    end else if ((ng % 8) == 0) begin
      r = 8;
    end else if ((ng % 4) == 0) begin
      r = 4;
    end else if ((ng % 2) == 0) begin
      r = 2;
    end else begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cla_group_unit.sv
// Combinational carry-lookahead unit over N propagate/generate pairs.
// carry[k] is the carry out of position k (carry into position k+1);
// p_out/g_out are the group propagate/generate for use at the next level.
module cla_group_unit #(
  parameter int N = 4
) (
  input  logic [N-1:0] p,
  input  logic [N-1:0] g,
  input  logic         cin,
  output logic [N-1:0] carry,
  output logic         p_out,
  output logic         g_out
);

  // Flat two-level lookahead: each carry is an OR of generate terms gated by
  // all higher propagates, plus cin gated by every propagate below it.
  always_comb begin
    logic acc_s;
    logic term_s;
    carry  = {N{1'b0}};
    g_out  = 1'b0;
    acc_s  = 1'b0;
    term_s = 1'b0;
    for (int k = 0; k < N; k++) begin
      term_s = cin;
      for (int j = 0; j <= k; j++) begin
        term_s = term_s & p[j];
      end
      acc_s = term_s;
      for (int j = 0; j <= k; j++) begin
        term_s = g[j];
        for (int m = j + 1; m <= k; m++) begin
          term_s = term_s & p[m];
        end
        acc_s = acc_s | term_s;
      end
      carry[k] = acc_s;
    end
    acc_s = 1'b0;
    for (int j = 0; j < N; j++) begin
      term_s = g[j];
      for (int m = j + 1; m < N; m++) begin
        term_s = term_s & p[m];
      end
      acc_s = acc_s | term_s;
    end
    g_out = acc_s;
  end

  assign p_out = &p;

endmodule

// File: rtl/cla_pipelined_adder.sv
// Pipelined carry-lookahead adder/subtractor with C/V/Z/N flags and
// valid/ready handshakes on both sides. With STAGES=2 the bit/group P/G terms
// are registered before the carry network; with STAGES=1 everything is
// computed from the inputs and registered once at the output.
module cla_pipelined_adder
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_z,
  output logic             flag_n
);

  localparam int NG  = WIDTH / GROUP;
  localparam int CH  = lka_chunk(NG);
  localparam int NCH = NG / CH;

  // ---------------- front end: operand conditioning and P/G ----------------
  logic [WIDTH-1:0] bb_s;
  logic             cin0_s;
  logic [WIDTH-1:0] p_s;
  logic [WIDTH-1:0] g_s;
  logic [NG-1:0]    gp_s;
  logic [NG-1:0]    gg_s;
  logic [WIDTH-1:0] front_carry_unused_s;

  // Invert B and pick the initial carry according to the operation.
  always_comb begin
    bb_s   = b;
    cin0_s = 1'b0;
    case (op_e'(op))
      OP_ADD: begin
        bb_s   = b;
        cin0_s = 1'b0;
      end
      OP_SUB: begin
        bb_s   = ~b;
        cin0_s = 1'b1;
      end
      OP_ADC: begin
        bb_s   = b;
        cin0_s = c_in;
      end
      OP_SBB: begin
        bb_s   = ~b;
        cin0_s = c_in;
      end
      default: begin
        bb_s   = b;
        cin0_s = 1'b0;
      end
    endcase
  end

  assign p_s = a ^ bb_s;
  assign g_s = a & bb_s;

  // First level: group propagate/generate only; carries here assume cin=0
  // and are recomputed later once the real group carry-in is known.
  for (genvar gi = 0; gi < NG; gi++) begin : g_front
    cla_group_unit #(.N(GROUP)) u_grp (
      .p     (p_s[gi*GROUP +: GROUP]),
      .g     (g_s[gi*GROUP +: GROUP]),
      .cin   (1'b0),
      .carry (front_carry_unused_s[gi*GROUP +: GROUP]),
      .p_out (gp_s[gi]),
      .g_out (gg_s[gi])
    );
  end

  // ---------------- optional stage-1 register ----------------
  logic             out_valid_q;
  logic             out_adv_s;
  logic             b_valid_s;
  logic [WIDTH-1:0] b_p_s;
  logic [WIDTH-1:0] b_g_s;
  logic [NG-1:0]    b_gp_s;
  logic [NG-1:0]    b_gg_s;
  logic             b_cin_s;

  // The output register can take new data when empty or being drained.
  assign out_adv_s = ~out_valid_q | out_ready;

  if (STAGES == 2) begin : g_two
    logic             s1_valid_q;
    logic             s1_valid_d;
    logic             s1_load_s;
    logic [WIDTH-1:0] s1_p_q;
    logic [WIDTH-1:0] s1_g_q;
    logic [NG-1:0]    s1_gp_q;
    logic [NG-1:0]    s1_gg_q;
    logic             s1_cin_q;

    assign in_ready = ~s1_valid_q | out_adv_s;

    // Stage-1 occupancy: refill on every accept slot, otherwise hold.
    always_comb begin
      s1_valid_d = s1_valid_q;
      s1_load_s  = 1'b0;
      if (in_ready) begin
        s1_valid_d = in_valid;
        s1_load_s  = in_valid;
      end else begin
        s1_valid_d = s1_valid_q;
        s1_load_s  = 1'b0;
      end
    end

    // Stage-1 register: P/G terms and carry-in of the accepted operation.
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_valid_q <= 1'b0;
        s1_p_q     <= {WIDTH{1'b0}};
        s1_g_q     <= {WIDTH{1'b0}};
        s1_gp_q    <= {NG{1'b0}};
        s1_gg_q    <= {NG{1'b0}};
        s1_cin_q   <= 1'b0;
      end else begin
        s1_valid_q <= s1_valid_d;
        if (s1_load_s) begin
          s1_p_q   <= p_s;
          s1_g_q   <= g_s;
          s1_gp_q  <= gp_s;
          s1_gg_q  <= gg_s;
          s1_cin_q <= cin0_s;
        end
      end
    end

    assign b_valid_s = s1_valid_q;
    assign b_p_s     = s1_p_q;
    assign b_g_s     = s1_g_q;
    assign b_gp_s    = s1_gp_q;
    assign b_gg_s    = s1_gg_q;
    assign b_cin_s   = s1_cin_q;
  end else begin : g_one
    assign in_ready  = out_adv_s;
    assign b_valid_s = in_valid;
    assign b_p_s     = p_s;
    assign b_g_s     = g_s;
    assign b_gp_s    = gp_s;
    assign b_gg_s    = gg_s;
    assign b_cin_s   = cin0_s;
  end

  // ---------------- back end: carries, sum and flags ----------------
  logic [NG-1:0]    gcarry_s;
  logic [NCH-1:0]   chunk_cin_s;
  logic [NCH-1:0]   lvl2_p_unused_s;
  logic [NCH-1:0]   lvl2_g_unused_s;
  logic [NG-1:0]    gcin_s;
  logic [WIDTH-1:0] bcarry_s;
  logic [NG-1:0]    bit_p_unused_s;
  logic [NG-1:0]    bit_g_unused_s;
  logic [WIDTH-1:0] cinto_s;
  logic [WIDTH-1:0] sum_s;

  // Second level: lookahead over group P/G, chained in chunks of <= 8 groups.
  for (genvar ci = 0; ci < NCH; ci++) begin : g_lvl2
    if (ci == 0) begin : g_first
      assign chunk_cin_s[ci] = b_cin_s;
    end else begin : g_next
      assign chunk_cin_s[ci] = gcarry_s[ci*CH-1];
    end
    cla_group_unit #(.N(CH)) u_lvl2 (
      .p     (b_gp_s[ci*CH +: CH]),
      .g     (b_gg_s[ci*CH +: CH]),
      .cin   (chunk_cin_s[ci]),
      .carry (gcarry_s[ci*CH +: CH]),
      .p_out (lvl2_p_unused_s[ci]),
      .g_out (lvl2_g_unused_s[ci])
    );
  end

  // Bit carries inside each group, seeded with that group's carry-in.
  for (genvar gi = 0; gi < NG; gi++) begin : g_bits
    if (gi == 0) begin : g_first
      assign gcin_s[gi] = b_cin_s;
    end else begin : g_next
      assign gcin_s[gi] = gcarry_s[gi-1];
    end
    cla_group_unit #(.N(GROUP)) u_bitc (
      .p     (b_p_s[gi*GROUP +: GROUP]),
      .g     (b_g_s[gi*GROUP +: GROUP]),
      .cin   (gcin_s[gi]),
      .carry (bcarry_s[gi*GROUP +: GROUP]),
      .p_out (bit_p_unused_s[gi]),
      .g_out (bit_g_unused_s[gi])
    );
  end

  assign cinto_s = {bcarry_s[WIDTH-2:0], b_cin_s};
  assign sum_s   = b_p_s ^ cinto_s;

  // Outputs of the lookahead units that duplicate information used elsewhere.
  logic unused_ok_s;
  assign unused_ok_s = ^{front_carry_unused_s, lvl2_p_unused_s, lvl2_g_unused_s,
                         bit_p_unused_s, bit_g_unused_s, gcarry_s[NG-1]};

  // ---------------- output register ----------------
  logic                 out_valid_d;
  logic [WIDTH-1:0]     sum_q;
  logic [WIDTH-1:0]     sum_d;
  logic [NUM_FLAGS-1:0] flags_q;
  logic [NUM_FLAGS-1:0] flags_d;

  // Load a new result only when the output slot frees up; otherwise hold so
  // the presented result stays stable under back-pressure.
  always_comb begin
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    flags_d     = flags_q;
    if (out_adv_s) begin
      out_valid_d = b_valid_s;
      if (b_valid_s) begin
        sum_d           = sum_s;
        flags_d[FLAG_C] = bcarry_s[WIDTH-1];
        flags_d[FLAG_V] = bcarry_s[WIDTH-1] ^ cinto_s[WIDTH-1];
        flags_d[FLAG_Z] = (sum_s == {WIDTH{1'b0}});
        flags_d[FLAG_N] = sum_s[WIDTH-1];
      end else begin
        sum_d   = sum_q;
        flags_d = flags_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output state register; reset clears the valid bit and the visible result.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= {WIDTH{1'b0}};
      flags_q     <= {NUM_FLAGS{1'b0}};
    end else begin
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign flag_c    = flags_q[FLAG_C];
  assign flag_v    = flags_q[FLAG_V];
  assign flag_z    = flags_q[FLAG_Z];
  assign flag_n    = flags_q[FLAG_N];

endmodule

// File: tb/tb_cla_pipelined_adder.sv
// Self-checking bench: directed cases and handshake checks on a 32/4/2
// instance, plus a randomized sweep over several WIDTH/GROUP/STAGES configs
// scored against a plain-arithmetic reference adder.
module tb_cla_pipelined_adder;
  import alu_pkg::*;

  localparam int NCFG = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic sweep_go;
  logic drain_chk;
  int   n_cmp;
  int   n_bad;

  // Directed-test handles of configuration 0 (32/4/2).
  logic        m_iv, m_ird, m_ov, m_ordy, m_cin, m_fc, m_fv, m_fz, m_fn;
  logic [1:0]  m_op;
  logic [31:0] m_a, m_b, m_sum;
  logic [35:0] m_held;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  for (genvar k = 0; k < NCFG; k++) begin : g_cfg
    localparam int W = (k == 0) ? 32 : (k == 1) ? 64 : (k == 2) ? 8 : (k == 3) ? 64 : (k == 4) ? 8 : 32;
    localparam int G = (k == 0) ? 4  : (k == 1) ? 8  : (k == 2) ? 2 : (k == 3) ? 2  : (k == 4) ? 8 : 2;
    localparam int S = (k == 0) ? 2  : (k == 1) ? 1  : (k == 2) ? 2 : (k == 3) ? 2  : (k == 4) ? 1 : 1;

    logic         iv, ird, ov, ordy, cin, fc, fv, fz, fn;
    logic [1:0]   op;
    logic [W-1:0] a, b, sum;
    logic         r_iv, r_ordy, r_cin;
    logic [1:0]   r_op;
    logic [W-1:0] r_a, r_b;
    logic [W+3:0] exp_q [$];
    logic [W+3:0] held, e, obs;
    logic         stalled;

    if (k == 0) begin : g_main
      assign iv    = sweep_go ? r_iv   : m_iv;
      assign ordy  = sweep_go ? r_ordy : m_ordy;
      assign op    = sweep_go ? r_op   : m_op;
      assign a     = sweep_go ? r_a    : m_a;
      assign b     = sweep_go ? r_b    : m_b;
      assign cin   = sweep_go ? r_cin  : m_cin;
      assign m_ird = ird;
      assign m_ov  = ov;
      assign m_sum = sum;
      assign m_fc  = fc;
      assign m_fv  = fv;
      assign m_fz  = fz;
      assign m_fn  = fn;
    end else begin : g_aux
      assign iv   = sweep_go & r_iv;
      assign ordy = ~sweep_go | r_ordy;
      assign op   = r_op;
      assign a    = r_a;
      assign b    = r_b;
      assign cin  = r_cin;
    end

    cla_pipelined_adder #(.WIDTH(W), .GROUP(G), .STAGES(S)) u_dut (
      .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ird), .op(op), .a(a), .b(b),
      .c_in(cin), .out_valid(ov), .out_ready(ordy), .sum(sum),
      .flag_c(fc), .flag_v(fv), .flag_z(fz), .flag_n(fn)
    );

    // Operand mix biased towards the interesting boundaries.
    function automatic logic [W-1:0] pick();
      logic [W-1:0] v;
      v = {W{1'b0}};
      case ($urandom_range(0, 9))
        0: v = {W{1'b0}};
        1: v = {W{1'b1}};
        2: v = {(W/2){2'b10}};
        3: v = {(W/2){2'b01}};
        4: v = {1'b1, {(W-1){1'b0}}};
        5: v = {1'b0, {(W-1){1'b1}}};
        default: for (int i = 0; i < W; i++) v[i] = 1'($urandom_range(0, 1));
      endcase
      return v;
    endfunction

    // Reference: plain (W+1)-bit addition; V from operand/result signs.
    function automatic logic [W+3:0] model(input logic [1:0] o, input logic [W-1:0] x,
                                           input logic [W-1:0] y, input logic ci);
      logic [W:0]   full;
      logic [W-1:0] yy, s;
      logic         c0, v;
      yy   = (o == OP_SUB || o == OP_SBB) ? ~y : y;
      c0   = (o == OP_ADD) ? 1'b0 : (o == OP_SUB) ? 1'b1 : ci;
      full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, c0};
      s    = full[W-1:0];
      v    = (x[W-1] == yy[W-1]) && (s[W-1] != x[W-1]);
      return {s[W-1], (s == {W{1'b0}}), v, full[W], s};
    endfunction

    initial begin
      r_iv = 1'b0; r_ordy = 1'b1; r_op = 2'b00; r_cin = 1'b0;
      r_a = {W{1'b0}}; r_b = {W{1'b0}};
      forever begin
        tick();
        if (sweep_go) begin
          r_iv   = ($urandom_range(0, 3) != 0);
          r_ordy = ($urandom_range(0, 4) != 0);
          r_op   = 2'($urandom_range(0, 3));
          r_cin  = 1'($urandom_range(0, 1));
          r_a    = pick();
          r_b    = pick();
        end else begin
          r_iv   = 1'b0;
          r_ordy = 1'b1;
        end
      end
    end

    initial stalled = 1'b0;

    always @(negedge clk) begin
      obs = {fn, fz, fv, fc, sum};
      if (rst) begin
        exp_q.delete();
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check($sformatf("c%0d_hold_valid", k), 128'(ov), 128'(1'b1));
          check($sformatf("c%0d_hold_data", k), 128'(obs), 128'(held));
        end
        if (ov && ordy) begin
          if (exp_q.size() == 0) begin
            check($sformatf("c%0d_spurious_out", k), 128'(1'b1), 128'(1'b0));
          end else begin
            e = exp_q.pop_front();
            check($sformatf("c%0d_result", k), 128'(obs), 128'(e));
          end
        end
        if (iv && ird) exp_q.push_back(model(op, a, b, cin));
        stalled = ov && !ordy;
        held    = obs;
      end
    end

    always @(negedge clk) begin
      if (drain_chk) check($sformatf("c%0d_drain", k), 128'(exp_q.size()), 128'(0));
    end
  end

  task automatic run_dir(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic ci, input logic [31:0] es,
                         input logic [3:0] ef);
    int cyc;
    m_op = o; m_a = x; m_b = y; m_cin = ci; m_iv = 1'b1;
    #1;
    check({tag, "_rdy"}, 128'(m_ird), 128'(1'b1));
    tick();
    m_iv = 1'b0;
    cyc  = 1;
    while (!m_ov && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, "_lat"}, 128'(cyc), 128'(2));
    check({tag, "_sum"}, 128'(m_sum), 128'(es));
    check({tag, "_nzvc"}, 128'({m_fn, m_fz, m_fv, m_fc}), 128'(ef));
    tick();
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; sweep_go = 1'b0; drain_chk = 1'b0;
    m_iv = 1'b0; m_ordy = 1'b1; m_op = 2'b00; m_a = 32'h0; m_b = 32'h0; m_cin = 1'b0;
    m_held = 36'h0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("rst_valid", 128'(m_ov), 128'(1'b0));
    check("rst_sum", 128'(m_sum), 128'(32'h0));
    check("rst_flags", 128'({m_fn, m_fz, m_fv, m_fc}), 128'(4'h0));
    check("rst_ready", 128'(m_ird), 128'(1'b1));

    // Directed cases; flag vector is {N,Z,V,C}.
    run_dir("add_wrap",   OP_ADD, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 4'b0101);
    run_dir("sub_ovf",    OP_SUB, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 4'b0011);
    run_dir("adc_ovf",    OP_ADC, 32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 4'b1010);
    run_dir("sbb_borrow", OP_SBB, 32'h00000005, 32'h00000005, 1'b0, 32'hFFFFFFFF, 4'b1000);
    run_dir("sub_cin_ign", OP_SUB, 32'h0000000A, 32'h00000003, 1'b1, 32'h00000007, 4'b0001);
    run_dir("add_cin_ign", OP_ADD, 32'h00000001, 32'h00000001, 1'b1, 32'h00000002, 4'b0000);

    // Back-to-back stream of 8 ADDs with out_ready held high.
    for (int i = 0; i <= 10; i++) begin
      tick();
      check("tp_ready", 128'(m_ird), 128'(1'b1));
      check("tp_valid", 128'(m_ov), 128'(i >= 2 && i <= 9));
      if (i < 8) begin
        m_iv = 1'b1; m_op = OP_ADD; m_a = $urandom; m_b = $urandom;
      end else begin
        m_iv = 1'b0;
      end
    end

    // Mid-stream stall of three cycles with the pipe full.
    for (int i = 0; i <= 13; i++) begin
      tick();
      m_ordy = !(i >= 4 && i <= 6);
      if (i < 10) begin
        m_iv = 1'b1; m_op = 2'($urandom_range(0, 3)); m_a = $urandom; m_b = $urandom;
        m_cin = 1'($urandom_range(0, 1));
      end else begin
        m_iv = 1'b0;
      end
      #1;
      if (i >= 4 && i <= 6) begin
        check("stall_ready", 128'(m_ird), 128'(1'b0));
        check("stall_valid", 128'(m_ov), 128'(1'b1));
        if (i == 4) m_held = {m_fn, m_fz, m_fv, m_fc, m_sum};
        else check("stall_frozen", 128'({m_fn, m_fz, m_fv, m_fc, m_sum}), 128'(m_held));
      end
    end

    // Fill the pipe under back-pressure, then reset for one cycle.
    m_ordy = 1'b0; m_iv = 1'b1; m_op = OP_ADD; m_a = 32'h12345678; m_b = 32'h11111111;
    repeat (3) tick();
    check("full_ready", 128'(m_ird), 128'(1'b0));
    rst = 1'b1; m_iv = 1'b0;
    tick();
    rst = 1'b0; m_ordy = 1'b1;
    #1;
    check("midrst_valid", 128'(m_ov), 128'(1'b0));
    check("midrst_sum", 128'(m_sum), 128'(32'h0));
    check("midrst_flags", 128'({m_fn, m_fz, m_fv, m_fc}), 128'(4'h0));
    check("midrst_ready", 128'(m_ird), 128'(1'b1));
    tick();
    check("midrst_nostale", 128'(m_ov), 128'(1'b0));
    run_dir("post_rst", OP_SUB, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 4'b0011);

    // Randomized sweep on every configuration with one reset in the middle.
    sweep_go = 1'b1;
    for (int i = 0; i < 900; i++) begin
      tick();
      rst = (i == 450);
    end
    rst = 1'b0;
    sweep_go = 1'b0; m_iv = 1'b0; m_ordy = 1'b1;
    repeat (12) tick();
    drain_chk = 1'b1;
    tick();
    drain_chk = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
